// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl
//   Decode-stage hazard controller built around a per-register scoreboard.
//   Each architectural register has a small counter that holds the number of
//   in-flight writes to it. The counter goes up when a writing instruction
//   issues from ID to EXE and goes down when WB writes the register back.
//   ID is stalled while any register it reads, or the register it is about to
//   write, is not yet safe to use. Because this uses counters rather than
//   pipeline compares, a change in EXE/MEM depth or a freeze cycle does not
//   need any special handling.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   src1, src2     source registers of the instruction in ID
//   Two_src        instruction in ID reads src2
//   ID_WB_EN       instruction in ID writes ID_Dest
//   ID_Dest        destination register of the instruction in ID
//   WB_WB_EN       WB writes WB_Dest this cycle
//   WB_Dest        destination register of the write-back
//   freeze         whole pipeline held: no issue, no retire
//   flush          instruction in ID squashed: no issue
//   hazard         stall IF/ID this cycle (combinational from the counters)
//   pending_any    at least one write is in flight
//   inflight       total in-flight writes, saturating at 15
//   sb_error       sticky flag: retire on an empty counter, or issue on a full one

module reg_scoreboard_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       Two_src,
  input  logic       ID_WB_EN,
  input  logic [3:0] ID_Dest,
  input  logic       WB_WB_EN,
  input  logic [3:0] WB_Dest,
  input  logic       freeze,
  input  logic       flush,
  output logic       hazard,
  output logic       pending_any,
  output logic [3:0] inflight,
  output logic       sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [3:0]       INF_MAX  = 4'hF;

  logic [CNT_W-1:0] cnt_r     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt_s [NUM_REGS];
  logic [3:0]       inflight_r;
  logic [3:0]       inflight_nxt_s;
  logic             sb_error_r;
  logic             sb_error_nxt_s;

  logic hazard_s;
  logic issue_s;
  logic retire_s;
  logic same_reg_s;
  logic eff_inc_s;
  logic eff_dec_s;
  logic overflow_s;
  logic underflow_s;

  // Stall decision and issue/retire qualification, all from registered counters.
  always_comb begin
    hazard_s   = (cnt_r[src1] != CNT_ZERO)
               | (Two_src  & (cnt_r[src2] != CNT_ZERO))
               | (ID_WB_EN & (cnt_r[ID_Dest] == CNT_MAX));
    issue_s    = ID_WB_EN & ~hazard_s & ~freeze & ~flush;
    retire_s   = WB_WB_EN & ~freeze;
    same_reg_s = (ID_Dest == WB_Dest);
    // An issue and a retire to the same register cancel, so neither can
    // overflow or underflow that counter.
    overflow_s  = issue_s  & (cnt_r[ID_Dest] == CNT_MAX)  & ~(retire_s & same_reg_s);
    underflow_s = retire_s & (cnt_r[WB_Dest] == CNT_ZERO) & ~(issue_s  & same_reg_s);
    // Only changes that actually move a counter are reflected in inflight,
    // which keeps it equal to the counter sum below saturation.
    eff_inc_s   = issue_s  & ~overflow_s;
    eff_dec_s   = retire_s & ~underflow_s;
  end

  // Per-register counter next state: +1 on issue, -1 on retire, clamped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      case ({issue_s & (ID_Dest == i[3:0]), retire_s & (WB_Dest == i[3:0])})
        2'b10: begin
          if (cnt_r[i] != CNT_MAX) begin
            cnt_nxt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        2'b01: begin
          if (cnt_r[i] != CNT_ZERO) begin
            cnt_nxt_s[i] = cnt_r[i] - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
    end
  end

  // Total in-flight count (saturating both ways) and sticky error next state.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({eff_inc_s, eff_dec_s})
      2'b10: begin
        if (inflight_r != INF_MAX) begin
          inflight_nxt_s = inflight_r + 4'd1;
        end else begin
          inflight_nxt_s = inflight_r;
        end
      end
      2'b01: begin
        if (inflight_r != 4'd0) begin
          inflight_nxt_s = inflight_r - 4'd1;
        end else begin
          inflight_nxt_s = inflight_r;
        end
      end
      default: inflight_nxt_s = inflight_r;
    endcase
    sb_error_nxt_s = sb_error_r | overflow_s | underflow_s;
  end

  // Scoreboard state registers; reset discards every in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      inflight_r <= 4'd0;
      sb_error_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      inflight_r <= inflight_nxt_s;
      sb_error_r <= sb_error_nxt_s;
    end
  end

  assign hazard      = hazard_s;
  assign pending_any = (inflight_r != 4'd0);
  assign inflight    = inflight_r;
  assign sb_error    = sb_error_r;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Self-checking bench for reg_scoreboard_ctrl. Each scenario task drives a
// table of per-cycle stimulus. Driving a row pushes its hand-derived expected
// outputs {hazard, pending_any, inflight, sb_error} onto a scoreboard queue.
// Inputs change 1 time unit after the rising edge, and the outputs are sampled
// and compared against the popped entry at the falling edge.

module tb_reg_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, ID_Dest, WB_Dest;
  logic       Two_src, ID_WB_EN, WB_WB_EN, freeze, flush;
  logic       hazard, pending_any, sb_error;
  logic [3:0] inflight;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       idwb;
    logic [3:0] iddst;
    logic       wbwb;
    logic [3:0] wbdst;
    logic       frz;
    logic       fl;
    logic [6:0] exp;  // {hazard, pending_any, inflight[3:0], sb_error}
  } step_t;

  logic [6:0] exp_q[$];

  reg_scoreboard_ctrl #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .ID_WB_EN(ID_WB_EN), .ID_Dest(ID_Dest), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest),
    .freeze(freeze), .flush(flush), .hazard(hazard), .pending_any(pending_any),
    .inflight(inflight), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // st(src1, src2, Two_src, ID_WB_EN, ID_Dest, WB_WB_EN, WB_Dest, freeze, flush,
  //    exp hazard, exp pending_any, exp inflight, exp sb_error)
  function automatic step_t st(input logic [3:0] a, input logic [3:0] b, input logic t,
                               input logic w, input logic [3:0] d, input logic r,
                               input logic [3:0] rd, input logic f, input logic fl,
                               input logic hz, input logic pd, input logic [3:0] inf,
                               input logic er);
    step_t s;
    s.src1 = a; s.src2 = b; s.two = t; s.idwb = w; s.iddst = d;
    s.wbwb = r; s.wbdst = rd; s.frz = f; s.fl = fl;
    s.exp  = {hz, pd, inf, er};
    return s;
  endfunction

  function automatic logic [6:0] obs();
    return {hazard, pending_any, inflight, sb_error};
  endfunction

  task automatic apply(input step_t s);
    src1 = s.src1; src2 = s.src2; Two_src = s.two; ID_WB_EN = s.idwb;
    ID_Dest = s.iddst; WB_WB_EN = s.wbwb; WB_Dest = s.wbdst;
    freeze = s.frz; flush = s.fl;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [6:0] e;
    step_t s;
    s = st(4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    apply(s);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs(), e);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply(s);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", obs(), e);
    end
  endtask

  task automatic test_issue_retire();
    step_t t[$];
    logic [6:0] e;
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    // Register 15 behaves like any other register.
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd15, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd15, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd15, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (t[i]) begin
      @(posedge clk); #1;
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL issue_retire step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_same_cycle();
    step_t t[$];
    logic [6:0] e;
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd5, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd5, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd6, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (t[i]) begin
      @(posedge clk); #1;
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL same_cycle step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    logic [6:0] e;
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
    // Counter full: the fourth writer of R7 is stalled and does not increment.
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0));
    t.push_back(st(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0));
    t.push_back(st(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0));
    t.push_back(st(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0));
    t.push_back(st(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (t[i]) begin
      @(posedge clk); #1;
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_freeze_flush();
    step_t t[$];
    logic [6:0] e;
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    // Frozen issue of R2 and frozen retire of R1: no counter moves, hazard still shown.
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    // Flushed issue of R4 with a concurrent retire of R1 that still proceeds.
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd4, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    // Busy src2 only matters when Two_src is set.
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd0, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd0, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
    t.push_back(st(4'd8, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (t[i]) begin
      @(posedge clk); #1;
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL freeze_flush step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_error_and_reset();
    step_t t[$];
    step_t idle;
    logic [6:0] e;
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1));
    t.push_back(st(4'd0, 4'd0, 1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1));
    t.push_back(st(4'd10, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1));
    foreach (t[i]) begin
      @(posedge clk); #1;
      apply(t[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL error_sticky step %0d: got %b expected %b", i, obs(), e);
      end
    end
    // Asynchronous reset between edges: outputs must clear before any clock edge.
    idle = st(4'd10, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    rst = 1'b1;
    apply(idle);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs(), e);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply(idle);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL after_reset: got %b expected %b", obs(), e);
    end
  endtask

  initial begin
    rst = 1'b1;
    src1 = 4'd0; src2 = 4'd0; Two_src = 1'b0; ID_WB_EN = 1'b0; ID_Dest = 4'd0;
    WB_WB_EN = 1'b0; WB_Dest = 4'd0; freeze = 1'b0; flush = 1'b0;
    test_reset();
    test_issue_retire();
    test_same_cycle();
    test_back_to_back();
    test_freeze_flush();
    test_error_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
